// File: rtl/line_raster_engine_if.sv
// line_raster_engine_if: start/endpoint request and pixel stream handshake for the line rasteriser.
interface line_raster_engine_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          start;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic          busy;
    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_last;
    logic          done;

    modport master (
        output start, x0, x1, y0, y1, pix_ready,
        input  busy, pix_valid, pix_x, pix_y, pix_last, done
    );

    modport slave (
        input  start, x0, x1, y0, y1, pix_ready,
        output busy, pix_valid, pix_x, pix_y, pix_last, done
    );
endinterface

// File: rtl/line_raster_engine.sv
// line_raster_engine: Bresenham rasteriser for any octant, streaming one pixel per
// valid/ready handshake from the endpoint with the smaller major coordinate.
module line_raster_engine #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input logic                 clk,
    input logic                 reset,
    line_raster_engine_if.slave bus
);
    localparam int W = (XW > YW) ? XW : YW;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [W-1:0]        ax_q, ay_q, bx_q, by_q, ax_d, ay_d, bx_d, by_d;
    logic [W-1:0]        maj_q, min_q, end_q, dx_q, dy_q;
    logic [W-1:0]        maj_d, min_d, end_d, dx_d, dy_d;
    logic                steep_q, steep_d, neg_q, neg_d;
    logic signed [W+1:0] err_q, err_d, err_sub;
    logic [W-1:0]        adx, ady, p0j, p0n, p1j, p1n, s_maj, s_min, e_maj, e_min, s_dx;
    logic                steep, swp, fire, last;

    // Setup: pick the major axis, then order endpoints so the major coordinate increases.
    assign adx   = (bx_q >= ax_q) ? bx_q - ax_q : ax_q - bx_q;
    assign ady   = (by_q >= ay_q) ? by_q - ay_q : ay_q - by_q;
    assign steep = ady > adx;
    assign p0j   = steep ? ay_q : ax_q;
    assign p0n   = steep ? ax_q : ay_q;
    assign p1j   = steep ? by_q : bx_q;
    assign p1n   = steep ? bx_q : by_q;
    assign swp   = p0j > p1j;
    assign s_maj = swp ? p1j : p0j;
    assign s_min = swp ? p1n : p0n;
    assign e_maj = swp ? p0j : p1j;
    assign e_min = swp ? p0n : p1n;
    assign s_dx  = e_maj - s_maj;

    assign last    = maj_q == end_q;
    assign fire    = (state_q == S_RUN) && bus.pix_ready;
    assign err_sub = err_q - $signed({2'b00, dy_q});

    assign bus.busy      = state_q != S_IDLE;
    assign bus.pix_valid = state_q == S_RUN;
    assign bus.pix_last  = (state_q == S_RUN) && last;
    assign bus.done      = state_q == S_DONE;
    assign bus.pix_x     = XW'(steep_q ? min_q : maj_q);
    assign bus.pix_y     = YW'(steep_q ? maj_q : min_q);

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        bx_d    = bx_q;
        by_d    = by_q;
        maj_d   = maj_q;
        min_d   = min_q;
        end_d   = end_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        steep_d = steep_q;
        neg_d   = neg_q;
        err_d   = err_q;
        if (state_q == S_IDLE && bus.start) begin
            ax_d    = W'(bus.x0);
            ay_d    = W'(bus.y0);
            bx_d    = W'(bus.x1);
            by_d    = W'(bus.y1);
            state_d = S_SETUP;
        end
        if (state_q == S_SETUP) begin
            steep_d = steep;
            maj_d   = s_maj;
            min_d   = s_min;
            end_d   = e_maj;
            dx_d    = s_dx;
            dy_d    = (e_min >= s_min) ? e_min - s_min : s_min - e_min;
            neg_d   = e_min < s_min;
            err_d   = $signed({3'b000, s_dx[W-1:1]});
            state_d = S_RUN;
        end
        if (fire && last) state_d = S_DONE;
        if (fire && !last) begin
            maj_d = maj_q + W'(1);
            err_d = err_sub[W+1] ? err_sub + $signed({2'b00, dx_q}) : err_sub;
            min_d = !err_sub[W+1] ? min_q : neg_q ? min_q - W'(1) : min_q + W'(1);
        end
        if (state_q == S_DONE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ax_q    <= '0;
            ay_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            maj_q   <= '0;
            min_q   <= '0;
            end_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            steep_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            maj_q   <= maj_d;
            min_q   <= min_d;
            end_q   <= end_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            steep_q <= steep_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_line_raster_engine.sv
// tb_line_raster_engine: directed and randomized lines against an integer Bresenham reference.
module tb_line_raster_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ex_x[$];
    int   ex_y[$];

    always #5 clk = ~clk;

    line_raster_engine_if #(.XW(10), .YW(9)) b ();
    line_raster_engine #(.XW(10), .YW(9)) dut (.clk(clk), .reset(reset), .bus(b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic void push(input int x, input int y);
        ex_x.push_back(x);
        ex_y.push_back(y);
    endfunction

    // Reference: textbook integer Bresenham producing the whole expected pixel list.
    function automatic void ref_line(input int ax, input int ay, input int bx, input int by);
        int t, dx, dy, err, ys, y;
        bit st;
        ex_x.delete();
        ex_y.delete();
        st = iabs(by - ay) > iabs(bx - ax);
        if (st) begin
            t = ax; ax = ay; ay = t;
            t = bx; bx = by; by = t;
        end
        if (ax > bx) begin
            t = ax; ax = bx; bx = t;
            t = ay; ay = by; by = t;
        end
        dx  = bx - ax;
        dy  = iabs(by - ay);
        err = dx / 2;
        ys  = (by >= ay) ? 1 : -1;
        y   = ay;
        for (int x = ax; x <= bx; x++) begin
            if (st) push(y, x);
            else push(x, y);
            err -= dy;
            if (err < 0) begin
                y += ys;
                err += dx;
            end
        end
    endfunction

    task automatic outs_zero(input string tag);
        chk({tag, "_busy"}, b.busy, 0);
        chk({tag, "_valid"}, b.pix_valid, 0);
        chk({tag, "_last"}, b.pix_last, 0);
        chk({tag, "_done"}, b.done, 0);
        chk({tag, "_x"}, b.pix_x, 0);
        chk({tag, "_y"}, b.pix_y, 0);
    endtask

    // Called at a negedge while idle; consumes ex_x/ex_y as the expected stream.
    task automatic draw(input int ax, input int ay, input int bx, input int by,
                        input int rdy_pct, input int stall_at, input int busy_at, input int abort_at);
        int  idx = 0;
        int  guard = 0;
        int  stall = 0;
        int  n = ex_x.size();
        bit  r;
        bit  pulsed = 0;
        b.start = 1'b1;
        b.x0 = 10'(ax);
        b.y0 = 9'(ay);
        b.x1 = 10'(bx);
        b.y1 = 9'(by);
        @(negedge clk);
        b.start = 1'b0;
        b.x0 = 10'($urandom);
        b.y0 = 9'($urandom);
        b.x1 = 10'($urandom);
        b.y1 = 9'($urandom);
        chk("setup_busy", b.busy, 1);
        chk("setup_valid", b.pix_valid, 0);
        chk("setup_done", b.done, 0);
        while (idx < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (idx == abort_at) begin
                #2 reset = 1'b0;
                #1 outs_zero("abort");
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_hold_valid", b.pix_valid, 0);
                    chk("abort_hold_done", b.done, 0);
                end
                reset = 1'b1;
                b.pix_ready = 1'b0;
                return;
            end
            chk("pix_valid", b.pix_valid, 1);
            chk("pix_x", b.pix_x, ex_x[idx]);
            chk("pix_y", b.pix_y, ex_y[idx]);
            chk("pix_last", b.pix_last, (idx == n - 1) ? 1 : 0);
            chk("run_done", b.done, 0);
            b.start = 1'b0;
            if (idx == busy_at && !pulsed) begin
                pulsed = 1;
                b.start = 1'b1;
                b.x0 = 10'($urandom);
                b.y0 = 9'($urandom);
                b.x1 = 10'($urandom);
                b.y1 = 9'($urandom);
            end
            if (idx == stall_at && stall < 3) begin
                stall++;
                r = 1'b0;
            end else r = $urandom_range(99) < rdy_pct;
            b.pix_ready = r;
            if (r) idx++;
        end
        chk("pixel_count", idx, n);
        @(negedge clk);
        b.start = 1'b0;
        b.pix_ready = 1'b0;
        chk("done_pulse", b.done, 1);
        chk("done_valid", b.pix_valid, 0);
        chk("done_busy", b.busy, 1);
        @(negedge clk);
        chk("idle_done", b.done, 0);
        chk("idle_busy", b.busy, 0);
    endtask

    initial begin
        int ax, ay, bx, by, bx0, by0;
        b.start = 1'b0;
        b.pix_ready = 1'b0;
        b.x0 = '0;
        b.y0 = '0;
        b.x1 = '0;
        b.y1 = '0;
        #1 reset = 1'b0;
        #2 outs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ex_x.delete(); ex_y.delete();
        for (int i = 1; i <= 6; i++) push(i, 1);
        draw(1, 1, 6, 1, 100, -1, -1, -1);
        ex_x.delete(); ex_y.delete();
        push(1, 1); push(1, 2); push(2, 3); push(2, 4); push(3, 5); push(3, 6);
        draw(1, 1, 3, 6, 100, -1, -1, -1);
        ex_x.delete(); ex_y.delete();
        push(1, 3); push(2, 3); push(3, 2); push(4, 2); push(5, 1); push(6, 1);
        draw(6, 1, 1, 3, 100, -1, -1, -1);
        ex_x.delete(); ex_y.delete();
        push(1, 1); push(2, 1); push(3, 2); push(4, 2); push(5, 3); push(6, 3);
        draw(1, 1, 6, 3, 100, 2, -1, -1);
        ex_x.delete(); ex_y.delete();
        push(5, 5);
        draw(5, 5, 5, 5, 100, -1, -1, -1);
        ex_x.delete(); ex_y.delete();
        push(1, 1); push(2, 1); push(3, 2); push(4, 2); push(5, 3); push(6, 3);
        draw(1, 1, 6, 3, 100, -1, 3, -1);
        ref_line(0, 0, 9, 0);
        draw(0, 0, 9, 0, 100, -1, -1, 3);
        @(negedge clk);
        ex_x.delete(); ex_y.delete();
        push(0, 0); push(1, 0); push(2, 0);
        draw(0, 0, 2, 0, 100, -1, -1, -1);
        ref_line(0, 511, 1023, 0);
        draw(0, 511, 1023, 0, 100, -1, -1, -1);
        for (int t = 0; t < 30; t++) begin
            bx0 = $urandom_range(960);
            by0 = $urandom_range(450);
            ax = bx0 + $urandom_range(60);
            bx = bx0 + $urandom_range(60);
            ay = by0 + $urandom_range(60);
            by = by0 + $urandom_range(60);
            ref_line(ax, ay, bx, by);
            draw(ax, ay, bx, by, $urandom_range(40, 100), $urandom_range(8) - 1, $urandom_range(8) - 1, -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/line_raster_engine.md
LINE_RASTER_ENGINE -- requirements
Module: line_raster_engine

Interface
REQ-001 SHALL have parameter XW, default 10, meaning pixel x-coordinate width.
REQ-002 SHALL have parameter YW, default 9, meaning pixel y-coordinate width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, request to draw the line given by x0/y0/x1/y1.
REQ-006 SHALL have ports x0 and x1, input, XW each, endpoint x-coordinates (unsigned).
REQ-007 SHALL have ports y0 and y1, input, YW each, endpoint y-coordinates (unsigned).
REQ-008 SHALL have port busy, output, 1, high from the start acceptance edge until done.
REQ-009 SHALL have port pix_valid, output, 1, pixel coordinate presented.
REQ-010 SHALL have port pix_ready, input, 1, downstream accepts the pixel.
REQ-011 SHALL have port pix_x, output, XW, pixel x.
REQ-012 SHALL have port pix_y, output, YW, pixel y.
REQ-013 SHALL have port pix_last, output, 1, final pixel of the line, qualified by pix_valid.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the last pixel handshake.

Function
REQ-015 SHALL handle all octants internally: no external swapping or ordering of endpoints required.
REQ-016 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored and SHALL NOT disturb the line in progress.
REQ-017 SHALL capture x0/y0/x1/y1 on the edge start is accepted; later input changes SHALL have no effect.
REQ-018 SHALL implement states IDLE -> SETUP (1 cycle) -> RUN -> DONE (1 cycle, done=1) -> IDLE.
REQ-019 SHALL in SETUP compute steep = |y1-y0| > |x1-x0|; if steep, swap x/y of both endpoints; then order endpoints so the major coordinate increases.
REQ-020 SHALL compute internally at width W = max(XW,YW); dx = major span, dy = |minor span|, ystep = +1 if the ordered minor end is greater, else -1 (0 span gives +1).
REQ-021 SHALL hold error in a signed register of W+2 bits, initialised to floor(dx/2).
REQ-022 SHALL in RUN, per accepted pixel: major += 1; err -= dy; if err < 0 then minor += ystep and err += dx.
REQ-023 SHALL emit exactly dx+1 pixels per line, from the endpoint with the smaller major coordinate to the larger.
REQ-024 SHALL output (pix_x, pix_y) = (minor, major) when steep, else (major, minor), truncated to XW/YW.
REQ-025 SHALL assert pix_valid throughout RUN; first pix_valid on the 2nd edge after the start edge (SETUP then RUN).
REQ-026 SHALL advance only when pix_valid && pix_ready; while pix_ready=0, pix_x, pix_y, pix_last and internal state SHALL hold stable.
REQ-027 SHALL sustain one pixel per cycle while pix_ready=1.
REQ-028 SHALL assert pix_last only with the (dx+1)-th pixel; its handshake moves RUN -> DONE.
REQ-029 SHALL treat a degenerate line (x0=x1, y0=y1) as one pixel with pix_last=1.
REQ-030 SHALL keep pix_valid=0 and done=0 in IDLE and SETUP; busy=1 in SETUP, RUN and DONE.
REQ-031 SHALL accept a new start in the cycle after done (IDLE), with no dead cycles beyond that.

Reset
REQ-032 SHALL, on reset=0, immediately (asynchronously) enter IDLE with busy, pix_valid, pix_last and done = 0, and pix_x, pix_y, error and counters = 0.
REQ-033 SHALL, if reset asserts mid-line, abandon the line with no further pixels and no done pulse; the next start after release SHALL draw normally.

Verification
REQ-034 SHALL cover horizontal: (1,1)->(6,1), pix_ready=1 -> pixels (1,1)..(6,1) on 6 consecutive cycles, pix_last on (6,1), done next cycle.
REQ-035 SHALL cover steep positive: (1,1)->(3,6) -> (1,1),(1,2),(2,3),(2,4),(3,5),(3,6).
REQ-036 SHALL cover reversed negative slope: (6,1)->(1,3) -> (1,3),(2,3),(3,2),(4,2),(5,1),(6,1).
REQ-037 SHALL cover backpressure: (1,1)->(6,3) with pix_ready=0 for 3 cycles after the 2nd pixel -> (3,2) held stable, sequence (1,1),(2,1),(3,2),(4,2),(5,3),(6,3) intact, no drop or duplicate.
REQ-038 SHALL cover degenerate plus start-while-busy: (5,5)->(5,5) -> single (5,5) with pix_last; start pulsed during RUN of a 6-pixel line -> ignored, line unchanged.
REQ-039 SHALL cover reset mid-run: reset=0 after the 3rd pixel -> all outputs 0 at once, no done; a new (0,0)->(2,0) afterwards -> (0,0),(1,0),(2,0).
